mw_writeback: RTL
=================

Name: mw_writeback

Overview:
- M/W pipeline register plus writeback logic. Sits directly downstream of the memory stage.
- Captures the memory stage's instruction, ALU result (O), load data (D), PC+1 and exception status on each clock.
- From the latched values it produces the register-file write port (we, rd, data), the W-stage bypass signals to execute, and a retired-instruction counter.

Parameters:
- WIDTH, 32, datapath width.
- REG_BITS, 5, register index width.
- STATUS_REG, 30, exception/setx destination.
- LINK_REG, 31, jal destination.

Ports:
- clock  in  1  single system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low; sampled on the rising edge of clock.
- in_valid  in  1  M stage holds a real instruction (0 = bubble).
- in_instruction  in  WIDTH  M-stage instruction.
- in_dataO  in  WIDTH  ALU result / address from M.
- in_dataD  in  WIDTH  data-memory read data from M.
- in_pc_plus1  in  WIDTH  PC+1 of the M instruction (jal link value).
- in_exc  in  1  M instruction raised an ALU exception.
- in_exc_code  in  WIDTH  status value to write to STATUS_REG (add 1, addi 2, sub 3, mul 4, div 5).
- stall  in  1  hold the W register.
- flush  in  1  load a bubble into the W register.
- ctrl_writeEnable  out  1  register-file write enable.
- ctrl_writeReg  out  REG_BITS  register-file destination.
- data_writeReg  out  WIDTH  register-file write data.
- bypass_rd  out  REG_BITS  equals ctrl_writeReg; for the execute bypass mux.
- bypass_we  out  1  equals ctrl_writeEnable.
- bypass_data  out  WIDTH  equals data_writeReg.
- retired_count  out  WIDTH  number of valid instructions that entered W.

Behaviour:
- W register contents: valid, instruction, dataO, dataD, pc_plus1, exc, exc_code.
- Per-edge priority: reset low > flush > stall > load.
  - reset low: clear all register fields and retired_count to 0.
  - flush: clear all register fields to 0; retired_count holds.
  - stall: all fields hold; retired_count holds.
  - load: capture inputs; retired_count += 1 iff in_valid = 1.
- retired_count wraps from 2^WIDTH-1 to 0 with no flag.
- Latency: a value presented at M appears on the write port one cycle later. Write-port outputs are purely combinational from the W register, with no additional register.
- Decode uses W opcode [31:27], rd [26:22], T [26:0]:
  - 00000 R-type: write rd, data = dataO.
  - 00101 addi: write rd, data = dataO.
  - 01000 lw: write rd, data = dataD.
  - 00011 jal: write LINK_REG, data = pc_plus1.
  - 10101 setx: write STATUS_REG, data = zero-extended T.
  - All other opcodes (sw, j, bne, blt, jr, bex, undefined): no write; ctrl_writeReg = rd, data = dataO.
- Exception override: if exc = 1 and the opcode is R-type or addi, write STATUS_REG with data = exc_code. This replaces the normal rd write.
- Write suppression: ctrl_writeEnable = valid & writes-per-decode & (destination != 0).
  - r0 is never written, including R-type with rd = 0 (nop = all-zero instruction).
- Bubble (valid = 0): ctrl_writeEnable = 0; other outputs follow decode of the zeroed instruction (reg 0, data 0 after reset/flush).
- Reset values: every output 0.
- Stall and flush both high: flush wins, bubble inserted.
- Reset mid-stall: cleared regardless of stall.

Decomposition:
- Shared package mw_pkg holds:
  - opcode constants OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_JAL, OP_SETX, and the rest of the ISA;
  - field-slice constants (opcode, rd, T positions);
  - exception code constants.
- One sub-module, wb_decode: combinational. Inputs are the W register fields; outputs are we, rd, data.
- The register and counter stay in mw_writeback.

Test Plan:
- Reset: hold reset low 2 cycles with in_valid = 1 and random data → all outputs 0, retired_count = 0.
- R-type then lw:
  - Load add r5 (instruction 0x01400000 | rd 5) with dataO = 0x0000_0007 → next cycle we = 1, writeReg = 5, data = 7.
  - Then lw r6 with dataD = 0xDEAD_BEEF, dataO = 0x10 → writeReg = 6, data = 0xDEADBEEF.
- jal/setx/exception:
  - jal with pc_plus1 = 0x42 → writeReg = 31, data = 0x42.
  - setx T = 0x123 → writeReg = 30, data = 0x123.
  - add with in_exc = 1, code = 1 → writeReg = 30, data = 1.
- r0 and non-writers:
  - nop (0x00000000, valid) → we = 0, retired_count increments.
  - sw → we = 0.
  - addi r0 with dataO = 9 → we = 0.
- Stall/flush:
  - Load addi r3 = 4, then stall 3 cycles → outputs hold writeReg = 3, data = 4, counter unchanged.
  - stall + flush together → we = 0, valid = 0.
- Counter wrap: force 2^32-1 retired instructions (or preload via long run in a fast sim/backdoor), then one valid load → retired_count = 0.

Source files
------------

// File: rtl/mw_pkg.sv
// -----------------------------------------------------------------------------
// mw_pkg
// Shared definitions for the M/W pipeline register and writeback logic:
//   - ISA opcode encodings (instruction bits [31:27])
//   - instruction field positions (opcode, rd, T)
//   - ALU exception status codes written to the status register
// -----------------------------------------------------------------------------
package mw_pkg;

    // Instruction field positions
    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 27;
    localparam int RD_HI     = 26;
    localparam int RD_LO     = 22;
    localparam int T_HI      = 26;
    localparam int T_LO      = 0;
    localparam int T_BITS    = T_HI - T_LO + 1;

    // Opcode encodings
    typedef enum logic [4:0] {
        OP_RTYPE = 5'b00000,
        OP_J     = 5'b00001,
        OP_BNE   = 5'b00010,
        OP_JAL   = 5'b00011,
        OP_JR    = 5'b00100,
        OP_ADDI  = 5'b00101,
        OP_BLT   = 5'b00110,
        OP_SW    = 5'b00111,
        OP_LW    = 5'b01000,
        OP_SETX  = 5'b10101,
        OP_BEX   = 5'b10110
    } opcode_e;

    // Status values written on an ALU exception
    localparam logic [31:0] EXC_ADD  = 32'd1;
    localparam logic [31:0] EXC_ADDI = 32'd2;
    localparam logic [31:0] EXC_SUB  = 32'd3;
    localparam logic [31:0] EXC_MUL  = 32'd4;
    localparam logic [31:0] EXC_DIV  = 32'd5;

endpackage

// File: rtl/mw_writeback_wb_decode.sv
// -----------------------------------------------------------------------------
// wb_decode
// Combinational writeback decode from the latched W-stage fields.
// Ports:
//   valid        in   W register holds a real instruction
//   instruction  in   W instruction
//   data_o       in   ALU result
//   data_d       in   load data
//   pc_plus1     in   link value for jal
//   exc          in   instruction raised an ALU exception
//   exc_code     in   status value for the exception
//   we           out  register-file write enable
//   rd           out  register-file destination
//   data         out  register-file write data
// -----------------------------------------------------------------------------
module wb_decode
    import mw_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int REG_BITS   = 5,
    parameter int STATUS_REG = 30,
    parameter int LINK_REG   = 31
) (
    input  logic                valid,
    input  logic [WIDTH-1:0]    instruction,
    input  logic [WIDTH-1:0]    data_o,
    input  logic [WIDTH-1:0]    data_d,
    input  logic [WIDTH-1:0]    pc_plus1,
    input  logic                exc,
    input  logic [WIDTH-1:0]    exc_code,
    output logic                we,
    output logic [REG_BITS-1:0] rd,
    output logic [WIDTH-1:0]    data
);

    logic [4:0] opcode;
    logic       writes;

    assign opcode = instruction[OPCODE_HI:OPCODE_LO];

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        writes = 1'b0;
        rd     = instruction[RD_HI:RD_LO];
        data   = data_o;

        case (opcode)
            OP_RTYPE, OP_ADDI: begin
                writes = 1'b1;
                // An overflowing ALU op reports into the status register
                // instead of touching its own destination.
                if (exc) begin
                    rd   = REG_BITS'(STATUS_REG);
                    data = exc_code;
                end
            end
            OP_LW: begin
                writes = 1'b1;
                data   = data_d;
            end
            OP_JAL: begin
                writes = 1'b1;
                rd     = REG_BITS'(LINK_REG);
                data   = pc_plus1;
            end
            OP_SETX: begin
                writes = 1'b1;
                rd     = REG_BITS'(STATUS_REG);
                data   = {{(WIDTH-T_BITS){1'b0}}, instruction[T_HI:T_LO]};
            end
            default: ;
        endcase

        // r0 is hardwired to zero, so a write to it is dropped here.
        we = valid & writes & (rd != '0);
    end

endmodule

// File: rtl/mw_writeback.sv
// -----------------------------------------------------------------------------
// mw_writeback
// M/W pipeline register plus writeback. Latches the memory-stage instruction
// and data each cycle, drives the register-file write port and W-stage bypass
// combinationally from the latched values, and counts retired instructions.
// Ports:
//   clock, reset              clock; synchronous active-low reset
//   in_valid .. in_exc_code   memory-stage instruction and data
//   stall / flush             hold the W register / load a bubble
//   ctrl_writeEnable, ctrl_writeReg, data_writeReg   register-file write port
//   bypass_we, bypass_rd, bypass_data                copies for execute bypass
//   retired_count             valid instructions that entered W (wraps)
// -----------------------------------------------------------------------------
module mw_writeback
    import mw_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int REG_BITS   = 5,
    parameter int STATUS_REG = 30,
    parameter int LINK_REG   = 31
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [WIDTH-1:0]    in_instruction,
    input  logic [WIDTH-1:0]    in_dataO,
    input  logic [WIDTH-1:0]    in_dataD,
    input  logic [WIDTH-1:0]    in_pc_plus1,
    input  logic                in_exc,
    input  logic [WIDTH-1:0]    in_exc_code,
    input  logic                stall,
    input  logic                flush,
    output logic                ctrl_writeEnable,
    output logic [REG_BITS-1:0] ctrl_writeReg,
    output logic [WIDTH-1:0]    data_writeReg,
    output logic [REG_BITS-1:0] bypass_rd,
    output logic                bypass_we,
    output logic [WIDTH-1:0]    bypass_data,
    output logic [WIDTH-1:0]    retired_count
);

    logic             valid_q;
    logic [WIDTH-1:0] instruction_q;
    logic [WIDTH-1:0] data_o_q;
    logic [WIDTH-1:0] data_d_q;
    logic [WIDTH-1:0] pc_plus1_q;
    logic             exc_q;
    logic [WIDTH-1:0] exc_code_q;
    logic [WIDTH-1:0] retired_q;

    // Priority: reset > flush > stall > load. Flush clears the fields but
    // leaves the counter alone, since nothing new has retired.
    always_ff @(posedge clock) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset) begin
            valid_q       <= 1'b0;
            instruction_q <= '0;
            data_o_q      <= '0;
            data_d_q      <= '0;
            pc_plus1_q    <= '0;
            exc_q         <= 1'b0;
            exc_code_q    <= '0;
            retired_q     <= '0;
        end else if (flush) begin
            valid_q       <= 1'b0;
            instruction_q <= '0;
            data_o_q      <= '0;
            data_d_q      <= '0;
            pc_plus1_q    <= '0;
            exc_q         <= 1'b0;
            exc_code_q    <= '0;
        end else if (!stall) begin
            valid_q       <= in_valid;
            instruction_q <= in_instruction;
            data_o_q      <= in_dataO;
            data_d_q      <= in_dataD;
            pc_plus1_q    <= in_pc_plus1;
            exc_q         <= in_exc;
            exc_code_q    <= in_exc_code;
            retired_q     <= retired_q + WIDTH'(in_valid);
        end
    end

    wb_decode #(
        .WIDTH      (WIDTH),
        .REG_BITS   (REG_BITS),
        .STATUS_REG (STATUS_REG),
        .LINK_REG   (LINK_REG)
    ) u_decode (
        .valid       (valid_q),
        .instruction (instruction_q),
        .data_o      (data_o_q),
        .data_d      (data_d_q),
        .pc_plus1    (pc_plus1_q),
        .exc         (exc_q),
        .exc_code    (exc_code_q),
        .we          (ctrl_writeEnable),
        .rd          (ctrl_writeReg),
        .data        (data_writeReg)
    );

    assign bypass_we     = ctrl_writeEnable;
    assign bypass_rd     = ctrl_writeReg;
    assign bypass_data   = data_writeReg;
    assign retired_count = retired_q;

endmodule
